operand_sel_pipe: RTL and testbench
===================================

OPERAND_SEL_PIPE -- requirements
Module: operand_sel_pipe

Interface
REQ-001 Parameter WIDTH, default 32: width of each data input and of data_o.
REQ-002 Parameter NUM_IN, default 4: number of data inputs; legal range 2..16.
REQ-003 Parameter SEL_W, default 2: width of select_i; SHALL be at least clog2(NUM_IN).
REQ-004 Parameter DEPTH, default 1: number of register stages between input and output; legal range 1..4.
REQ-005 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_i  input  1  reset; asynchronous and active-low.
REQ-007 data_i  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-008 select_i  input  SEL_W  binary index of the input to pass.
REQ-009 valid_i  input  1  marks data_i and select_i as meaningful this cycle.
REQ-010 stall_i  input  1  freeze all stages.
REQ-011 flush_i  input  1  invalidate all stages.
REQ-012 clr_err_i  input  1  clear the sticky error flag.
REQ-013 data_o  output  WIDTH  selected data after DEPTH cycles.
REQ-014 valid_o  output  1  valid bit of the last stage.
REQ-015 sel_err_o  output  1  sticky flag: an out-of-range select was accepted.
REQ-016 err_cnt_o  output  8  saturating count of out-of-range selects accepted.

Function
REQ-017 Selection SHALL follow these rules:
- select_i < NUM_IN: selected value = input[select_i].
- select_i >= NUM_IN: selected value = all zeros.
REQ-018 The selected value and valid_i SHALL enter stage 1 on each non-stalled edge.
REQ-019 Each stage n>1 SHALL load stage n-1 on each non-stalled edge.
REQ-020 data_o and valid_o SHALL be the last stage's registers; latency is exactly DEPTH cycles.
REQ-021 Stall: with stall_i=1 and flush_i=0, every stage SHALL hold data and valid unchanged, and inputs SHALL be ignored.
REQ-022 Flush: with flush_i=1, every stage's valid SHALL clear on that edge; data registers SHALL clear to zero.
REQ-023 Flush SHALL take priority over stall.
REQ-024 "Accepted" means valid_i=1, stall_i=0 and flush_i=0 on the edge.
REQ-025 An accepted select_i >= NUM_IN SHALL set sel_err_o on that edge.
REQ-026 An accepted select_i >= NUM_IN SHALL increment err_cnt_o, saturating at 255.
REQ-027 clr_err_i=1 SHALL clear sel_err_o and err_cnt_o on that edge.
REQ-028 If clr_err_i and an error-setting event occur on the same edge, the clear SHALL win.
REQ-029 Selects made with valid_i=0 SHALL still pass data through the stages.
REQ-030 Selects made with valid_i=0 SHALL never affect sel_err_o or err_cnt_o.
REQ-031 No output SHALL depend combinationally on any input.

Reset
REQ-032 rst_i=0 SHALL immediately clear, regardless of clk_i:
- all stage data registers;
- all stage valid bits;
- sel_err_o and err_cnt_o.
REQ-033 Reset asserted mid-pipeline SHALL discard all in-flight entries; no entry SHALL emerge after reset is released.
REQ-034 The first edge after reset is released SHALL behave as a normal edge.

Structure
REQ-035 The following SHALL live in the shared CPU package:
- default constants for WIDTH, NUM_IN, DEPTH;
- the err_cnt width constant (8).
REQ-036 One sub-module, pipe_stage_reg, SHALL implement a single stage (data plus valid, with stall, flush and async reset).
REQ-037 pipe_stage_reg SHALL be instantiated DEPTH times via generate.
REQ-038 Selection logic and error counter SHALL reside in operand_sel_pipe.

Verification
REQ-039 Reset: set DEPTH=2, hold rst_i=0 for 3 cycles with random inputs -> data_o=0, valid_o=0, sel_err_o=0, err_cnt_o=0 throughout.
REQ-040 Basic select: set NUM_IN=4, DEPTH=2, inputs 0x11,0x22,0x33,0x44; apply select 0,1,2,3 with valid_i=1 on consecutive cycles -> data_o shows 0x11,0x22,0x33,0x44 starting 2 cycles later, with valid_o=1.
REQ-041 Out-of-range: set NUM_IN=3, SEL_W=2; apply select_i=3, valid_i=1 for 2 cycles -> data_o=0 after latency, sel_err_o=1, err_cnt_o=2.
REQ-042 Clear plus error: assert clr_err_i on the same edge as another accepted error -> sel_err_o=0, err_cnt_o=0.
REQ-043 Stall/flush: set DEPTH=3 with 3 valid entries in flight.
- stall_i=1 for 2 cycles -> outputs frozen.
- then stall_i=1 and flush_i=1 together -> valid_o=0 next cycle, and no entry emerges later.
REQ-044 Saturation and async reset:
- 300 accepted out-of-range selects -> err_cnt_o=255.
- Then drop rst_i between clock edges -> all outputs reset before the next edge.

Source files
------------

// File: rtl/operand_sel_pipe_pkg.sv
// ---------------------------------------------------------------------------
// operand_sel_pipe_pkg
//   Shared constants for the operand select pipeline: default data width,
//   input count, select width and pipeline depth, plus the width and
//   saturation value of the error counter.
// ---------------------------------------------------------------------------
package operand_sel_pipe_pkg;

   localparam int unsigned OSP_WIDTH   = 32;
   localparam int unsigned OSP_NUM_IN  = 4;
   localparam int unsigned OSP_SEL_W   = 2;
   localparam int unsigned OSP_DEPTH   = 1;

   localparam int unsigned ERR_CNT_W   = 8;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/operand_sel_pipe_stage.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   One pipeline stage: a data register plus its valid bit.
//   Ports:
//     clk_i    rising-edge clock
//     rst_i    asynchronous active-low reset (clears data and valid)
//     stall_i  hold the current contents
//     flush_i  clear data and valid (wins over stall_i)
//     data_i   data from the previous stage
//     valid_i  valid from the previous stage
//     data_o   registered data
//     valid_o  registered valid
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o
);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         data_o  <= '0;
         valid_o <= 1'b0;
      end else if (flush_i) begin
         data_o  <= '0;
         valid_o <= 1'b0;
      end else if (!stall_i) begin
         data_o  <= data_i;
         valid_o <= valid_i;
      end
   end

endmodule

// File: rtl/operand_sel_pipe.sv
// ---------------------------------------------------------------------------
// operand_sel_pipe
//   Selects one of NUM_IN flattened inputs by binary index and carries it,
//   with its valid bit, through DEPTH register stages. Out-of-range selects
//   produce zero data; when accepted they set a sticky error flag and bump a
//   saturating error counter.
//   Ports:
//     clk_i      rising-edge clock
//     rst_i      asynchronous active-low reset
//     data_i     NUM_IN*WIDTH flattened inputs, input k at [k*WIDTH +: WIDTH]
//     select_i   binary index of the input to pass
//     valid_i    data_i/select_i meaningful this cycle
//     stall_i    freeze all stages
//     flush_i    invalidate all stages (wins over stall_i)
//     clr_err_i  clear sel_err_o and err_cnt_o (wins over a new error)
//     data_o     last-stage data
//     valid_o    last-stage valid
//     sel_err_o  sticky out-of-range flag
//     err_cnt_o  saturating count of accepted out-of-range selects
// ---------------------------------------------------------------------------
module operand_sel_pipe
   import operand_sel_pipe_pkg::*;
#(
   parameter int unsigned WIDTH  = OSP_WIDTH,
   parameter int unsigned NUM_IN = OSP_NUM_IN,
   parameter int unsigned SEL_W  = OSP_SEL_W,
   parameter int unsigned DEPTH  = OSP_DEPTH
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NUM_IN*WIDTH-1:0] data_i,
   input  logic [SEL_W-1:0]        select_i,
   input  logic                    valid_i,
   input  logic                    stall_i,
   input  logic                    flush_i,
   input  logic                    clr_err_i,
   output logic [WIDTH-1:0]        data_o,
   output logic                    valid_o,
   output logic                    sel_err_o,
   output logic [ERR_CNT_W-1:0]    err_cnt_o
);

   // One extra bit so NUM_IN is representable even when NUM_IN == 2**SEL_W.
   localparam logic [SEL_W:0] NUM_IN_C = (SEL_W+1)'(NUM_IN);

   logic             sel_oor;
   logic             accepted;
   logic [WIDTH-1:0] sel_data;

   logic [WIDTH-1:0] stg_data  [0:DEPTH];
   logic             stg_valid [0:DEPTH];

   assign sel_oor  = ({1'b0, select_i} >= NUM_IN_C);
   assign accepted = valid_i & ~stall_i & ~flush_i;

   always_comb begin
      sel_data = '0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if ({1'b0, select_i} == (SEL_W+1)'(k)) begin
            sel_data = data_i[k*WIDTH +: WIDTH];
         end
      end
   end

   assign stg_data[0]  = sel_data;
   assign stg_valid[0] = valid_i;

   for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      pipe_stage_reg #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .stall_i (stall_i),
         .flush_i (flush_i),
         .data_i  (stg_data[s]),
         .valid_i (stg_valid[s]),
         .data_o  (stg_data[s+1]),
         .valid_o (stg_valid[s+1])
      );
   end

   assign data_o  = stg_data[DEPTH];
   assign valid_o = stg_valid[DEPTH];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sel_err_o <= 1'b0;
         err_cnt_o <= '0;
      end else if (clr_err_i) begin
         sel_err_o <= 1'b0;
         err_cnt_o <= '0;
      end else if (accepted && sel_oor) begin
         sel_err_o <= 1'b1;
         if (err_cnt_o != ERR_CNT_MAX) begin
            err_cnt_o <= err_cnt_o + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_operand_sel_pipe.sv
module tb_operand_sel_pipe;

   logic        clk;
   logic        rst_n;
   logic [31:0] data_a;
   logic [23:0] data_b;
   logic [1:0]  sel;
   logic        valid, stall, flush, clr;

   logic [7:0]  a_data, b_data, c_data;
   logic        a_valid, b_valid, c_valid;
   logic        a_err, b_err, c_err;
   logic [7:0]  a_cnt, b_cnt, c_cnt;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [7:0] exp_seq [0:3];

   // NUM_IN=4, DEPTH=2
   operand_sel_pipe #(.WIDTH(8), .NUM_IN(4), .SEL_W(2), .DEPTH(2)) dut_a (
      .clk_i(clk), .rst_i(rst_n), .data_i(data_a), .select_i(sel),
      .valid_i(valid), .stall_i(stall), .flush_i(flush), .clr_err_i(clr),
      .data_o(a_data), .valid_o(a_valid), .sel_err_o(a_err), .err_cnt_o(a_cnt));

   // NUM_IN=3, DEPTH=2: select 3 is out of range
   operand_sel_pipe #(.WIDTH(8), .NUM_IN(3), .SEL_W(2), .DEPTH(2)) dut_b (
      .clk_i(clk), .rst_i(rst_n), .data_i(data_b), .select_i(sel),
      .valid_i(valid), .stall_i(stall), .flush_i(flush), .clr_err_i(clr),
      .data_o(b_data), .valid_o(b_valid), .sel_err_o(b_err), .err_cnt_o(b_cnt));

   // NUM_IN=4, DEPTH=3
   operand_sel_pipe #(.WIDTH(8), .NUM_IN(4), .SEL_W(2), .DEPTH(3)) dut_c (
      .clk_i(clk), .rst_i(rst_n), .data_i(data_a), .select_i(sel),
      .valid_i(valid), .stall_i(stall), .flush_i(flush), .clr_err_i(clr),
      .data_o(c_data), .valid_o(c_valid), .sel_err_o(c_err), .err_cnt_o(c_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33; exp_seq[3] = 8'h44;
      rst_n = 1'b0;
      data_a = '0; data_b = '0; sel = '0;
      valid = 1'b0; stall = 1'b0; flush = 1'b0; clr = 1'b0;

      // Reset held for 3 cycles with random inputs
      for (int i = 0; i < 3; i++) begin
         data_a = $urandom;
         data_b = 24'($urandom);
         sel    = 2'($urandom_range(0, 3));
         valid  = 1'($urandom_range(0, 1));
         stall  = 1'($urandom_range(0, 1));
         flush  = 1'($urandom_range(0, 1));
         clr    = 1'($urandom_range(0, 1));
         step();
         check("rst_data",  32'(a_data),  32'h0);
         check("rst_valid", 32'(a_valid), 32'h0);
         check("rst_err",   32'(a_err),   32'h0);
         check("rst_cnt",   32'(a_cnt),   32'h0);
      end

      // Release reset between edges; basic select 0..3 on A (DEPTH=2)
      data_a = 32'h4433_2211;
      data_b = 24'h33_2211;
      stall = 1'b0; flush = 1'b0; clr = 1'b0; valid = 1'b0; sel = '0;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            sel = 2'(i); valid = 1'b1;
         end else begin
            sel = '0; valid = 1'b0;
         end
         step();
         if (i == 0) check("lat_not_yet", 32'(a_valid), 32'h0);
         if (i >= 1) begin
            check("sel_data",  32'(a_data),  32'(exp_seq[i-1]));
            check("sel_valid", 32'(a_valid), 32'h1);
         end
      end
      check("a_no_err", 32'(a_err), 32'h0);

      // Clear B (it accepted select 3 above)
      clr = 1'b1; step(); clr = 1'b0;
      check("b_clr_err", 32'(b_err), 32'h0);
      check("b_clr_cnt", 32'(b_cnt), 32'h0);

      // Out-of-range on B: select 3 twice
      sel = 2'd3; valid = 1'b1;
      step();
      step();
      check("oor_data",  32'(b_data),  32'h0);
      check("oor_valid", 32'(b_valid), 32'h1);
      check("oor_err",   32'(b_err),   32'h1);
      check("oor_cnt",   32'(b_cnt),   32'h2);

      // Clear coincident with an accepted error: clear wins
      clr = 1'b1; step(); clr = 1'b0;
      check("clrwin_err", 32'(b_err), 32'h0);
      check("clrwin_cnt", 32'(b_cnt), 32'h0);

      // Three valid entries into C (DEPTH=3)
      for (int i = 0; i < 3; i++) begin
         sel = 2'(i); valid = 1'b1;
         step();
      end
      check("c_fill_data",  32'(c_data),  32'h11);
      check("c_fill_valid", 32'(c_valid), 32'h1);

      // Stall 2 cycles with an out-of-range select: frozen, not accepted
      stall = 1'b1; sel = 2'd3; valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("stall_data",  32'(c_data),  32'h11);
         check("stall_valid", 32'(c_valid), 32'h1);
      end
      check("stall_no_cnt", 32'(b_cnt), 32'h0);

      // Stall + flush together: flush wins
      flush = 1'b1;
      step();
      check("flush_valid", 32'(c_valid), 32'h0);
      check("flush_data",  32'(c_data),  32'h0);

      // valid_i=0 data still flows, no entry emerges, no error counted
      stall = 1'b0; flush = 1'b0; valid = 1'b0; sel = 2'd3;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_flush_valid", 32'(c_valid), 32'h0);
      end
      check("inval_data", 32'(c_data), 32'h44);
      check("inval_err",  32'(b_err),  32'h0);
      check("inval_cnt",  32'(b_cnt),  32'h0);

      // Saturation
      valid = 1'b1; sel = 2'd3;
      for (int i = 0; i < 300; i++) step();
      check("sat_cnt", 32'(b_cnt), 32'd255);
      check("sat_err", 32'(b_err), 32'h1);
      check("a_cnt_zero", 32'(a_cnt), 32'h0);

      // Asynchronous reset between edges
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_b_cnt",   32'(b_cnt),   32'h0);
      check("arst_b_err",   32'(b_err),   32'h0);
      check("arst_b_valid", 32'(b_valid), 32'h0);
      check("arst_c_valid", 32'(c_valid), 32'h0);
      check("arst_a_data",  32'(a_data),  32'h0);

      // After release, nothing in flight emerges
      step();
      valid = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_rst_valid", 32'(c_valid), 32'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
